pmem_arbiter: RTL

Sequences the single 256-bit physical-memory port between the instruction cache and the data cache. Each cache keeps its own cacheline port (read, write, address, 256-bit data, response) and sees a private, always-available memory. The arbiter accepts one line transaction at a time, grants round-robin when both caches request, and routes the response back to the owner. It sits between the two cache instances and the main-memory model or next-level cache.

---
 rtl/pmem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_arbiter
//
// Shares one cacheline-wide physical-memory port between the instruction
// cache and the data cache. Only one line transaction is in flight at a time.
// When both caches ask in the same cycle, the one that was not served most
// recently wins. The response is routed back to whichever cache owns the
// transaction. Each cache sees what looks like a private memory.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   i_read          I-cache line read request (level, held until i_resp)
//   i_address       I-cache line address
//   i_rdata         line data to I-cache (qualified by i_resp)
//   i_resp          one-cycle completion pulse to I-cache
//   d_read          D-cache line read request (level, held until d_resp)
//   d_write         D-cache line write-back request (level, held until d_resp)
//   d_address       D-cache line address
//   d_wdata         D-cache write-back line
//   d_rdata         line data to D-cache (qualified by d_resp)
//   d_resp          one-cycle completion pulse to D-cache
//   pmem_read       memory read strobe, held until pmem_resp
//   pmem_write      memory write strobe, held until pmem_resp
//   pmem_address    latched line address, offset bits cleared
//   pmem_wdata      latched write-back line
//   pmem_rdata      memory read data, valid with pmem_resp
//   pmem_resp       memory completion pulse
// ---------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_t;

    // Clears the byte-offset bits so memory always sees a line-aligned address.
    localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_grant;   // 0: I served last, 1: D served last
    logic [31:0]         r_addr_q;
    logic [s_line-1:0]   r_wdata_q;

    logic                w_d_pend;
    logic                w_grant_i;
    logic                w_grant_d;

    assign w_d_pend = d_read | d_write;

    // Next state, grant decision and strobes/responses.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;

        case (r_state)
            IDLE: begin
                // On a tie, serve the cache that did not get the last grant.
                if (i_read && w_d_pend) begin
                    if (r_last_grant) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else if (i_read) begin
                    w_grant_i = 1'b1;
                end else if (w_d_pend) begin
                    w_grant_d = 1'b1;
                end

                if (w_grant_i) begin
                    w_state_nxt = I_RD;
                end else if (w_grant_d) begin
                    // A simultaneous read+write from the D-cache is a write.
                    w_state_nxt = d_write ? D_WR : D_RD;
                end
            end

            I_RD: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_resp      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            D_RD: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    d_resp      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            D_WR: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    d_resp      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and per-transaction latches. Reset abandons any
    // in-flight transaction without issuing a response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_i) begin
                r_addr_q     <= i_address & LINE_MASK;
                r_last_grant <= 1'b0;
            end else if (w_grant_d) begin
                r_addr_q     <= d_address & LINE_MASK;
                r_last_grant <= 1'b1;
                if (d_write) begin
                    r_wdata_q <= d_wdata;
                end
            end
        end
    end

    assign pmem_address = r_addr_q;
    assign pmem_wdata   = r_wdata_q;

    // Read data is broadcast; only the owner's resp pulse qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
